// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles every bus signal around the two-master memory arbiter: the
//   instruction-cache request port (ic_*), the data-cache request port (dc_*)
//   and the single downstream memory port (mem_*).
//
//   Modports
//     slave  : the arbiter's view. It takes cache requests and memory
//              responses in, and drives wait/valid/data back to the caches
//              plus the merged request towards memory.
//     master : the environment's view (caches plus memory model). It is the
//              exact mirror of the slave modport.
//
//   Signals (AW = ADDR_WIDTH, DW = DATA_WIDTH, BW = BURSTLEN_WIDTH)
//     ic_addr[AW], ic_burst_len[BW], ic_rd                  cache -> arbiter
//     ic_waitrequest, ic_rd_valid, ic_data_out[DW]          arbiter -> cache
//     dc_addr[AW], dc_burst_len[BW], dc_data_in[DW],
//     dc_rd, dc_wr                                          cache -> arbiter
//     dc_waitrequest, dc_rd_valid, dc_data_out[DW]          arbiter -> cache
//     mem_addr[AW], mem_burst_len[BW], mem_data_in[DW],
//     mem_rd, mem_wr                                        arbiter -> memory
//     mem_waitrequest, mem_rd_valid, mem_data_out[DW]       memory -> arbiter
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BURSTLEN_WIDTH = 2
);

    // Instruction-cache port
    logic [ADDR_WIDTH-1:0]     ic_addr;
    logic [BURSTLEN_WIDTH-1:0] ic_burst_len;
    logic                      ic_rd;
    logic                      ic_waitrequest;
    logic                      ic_rd_valid;
    logic [DATA_WIDTH-1:0]     ic_data_out;

    // Data-cache port
    logic [ADDR_WIDTH-1:0]     dc_addr;
    logic [BURSTLEN_WIDTH-1:0] dc_burst_len;
    logic [DATA_WIDTH-1:0]     dc_data_in;
    logic                      dc_rd;
    logic                      dc_wr;
    logic                      dc_waitrequest;
    logic                      dc_rd_valid;
    logic [DATA_WIDTH-1:0]     dc_data_out;

    // Memory port
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [BURSTLEN_WIDTH-1:0] mem_burst_len;
    logic [DATA_WIDTH-1:0]     mem_data_in;
    logic                      mem_rd;
    logic                      mem_wr;
    logic                      mem_waitrequest;
    logic                      mem_rd_valid;
    logic [DATA_WIDTH-1:0]     mem_data_out;

    // Arbiter side
    modport slave (
        input  ic_addr, ic_burst_len, ic_rd,
        output ic_waitrequest, ic_rd_valid, ic_data_out,
        input  dc_addr, dc_burst_len, dc_data_in, dc_rd, dc_wr,
        output dc_waitrequest, dc_rd_valid, dc_data_out,
        output mem_addr, mem_burst_len, mem_data_in, mem_rd, mem_wr,
        input  mem_waitrequest, mem_rd_valid, mem_data_out
    );

    // Caches plus memory side
    modport master (
        output ic_addr, ic_burst_len, ic_rd,
        input  ic_waitrequest, ic_rd_valid, ic_data_out,
        output dc_addr, dc_burst_len, dc_data_in, dc_rd, dc_wr,
        input  dc_waitrequest, dc_rd_valid, dc_data_out,
        input  mem_addr, mem_burst_len, mem_data_in, mem_rd, mem_wr,
        output mem_waitrequest, mem_rd_valid, mem_data_out
    );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Merges instruction-cache and data-cache requests onto the single memory
//   port. Reads are wrap bursts of burst_len+1 beats and writes are single
//   beats. When both caches request in the same cycle the grant alternates
//   (round-robin on the last accepted master). Read beats are forwarded,
//   one cycle after they arrive, to the master that owns the open burst.
//
//   Ports
//     clock    : single clock, all logic on the rising edge
//     reset_n  : synchronous, active-low reset
//     bus      : mem_arbiter_if.slave, carrying the ic_*, dc_* and mem_*
//                request/response signals
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BURSTLEN_WIDTH = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IC = 2'd1,
        RD_DC = 2'd2
    } state_t;

    typedef enum logic {
        MASTER_IC = 1'b0,
        MASTER_DC = 1'b1
    } master_t;

    state_t                    state;
    master_t                   last_grant;
    logic [BURSTLEN_WIDTH-1:0] beat_cnt;

    logic                      ic_rd_valid_q;
    logic                      dc_rd_valid_q;
    logic [DATA_WIDTH-1:0]     ic_data_q;
    logic [DATA_WIDTH-1:0]     dc_data_q;

    logic req_ic;
    logic req_dc;
    logic grant_ic;
    logic grant_dc;
    logic accept_ic;
    logic accept_dc;

    // Arbitration. Grants only exist in IDLE and outside reset, so the memory
    // strobes stay low while reset_n is held low. On a conflict the master
    // that was not accepted last wins; a stalled grant does not move
    // last_grant, so the same master keeps the grant until memory accepts.
    always_comb begin
        req_ic   = bus.ic_rd;
        req_dc   = bus.dc_rd | bus.dc_wr;
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        if (reset_n && (state == IDLE)) begin
            if (req_ic && req_dc) begin
                grant_ic = (last_grant == MASTER_DC);
                grant_dc = (last_grant == MASTER_IC);
            end else begin
                grant_ic = req_ic;
                grant_dc = req_dc;
            end
        end
        accept_ic = grant_ic & ~bus.mem_waitrequest;
        accept_dc = grant_dc & ~bus.mem_waitrequest;
    end

    // Memory request mux. The granted master's fields go straight through;
    // with no grant everything reads as zero. When the data cache raises
    // rd and wr together the write wins and the read is suppressed.
    always_comb begin
        bus.mem_addr      = '0;
        bus.mem_burst_len = '0;
        bus.mem_data_in   = '0;
        bus.mem_rd        = 1'b0;
        bus.mem_wr        = 1'b0;
        if (grant_ic) begin
            bus.mem_addr      = bus.ic_addr;
            bus.mem_burst_len = bus.ic_burst_len;
            bus.mem_rd        = 1'b1;
        end else if (grant_dc) begin
            bus.mem_addr      = bus.dc_addr;
            bus.mem_burst_len = bus.dc_burst_len;
            bus.mem_data_in   = bus.dc_data_in;
            bus.mem_rd        = bus.dc_rd & ~bus.dc_wr;
            bus.mem_wr        = bus.dc_wr;
        end
    end

    // A requesting master waits in every cycle it is not accepted, which
    // covers losing arbitration, a memory stall and an open burst.
    assign bus.ic_waitrequest = req_ic & ~accept_ic;
    assign bus.dc_waitrequest = req_dc & ~accept_dc;

    assign bus.ic_rd_valid = ic_rd_valid_q;
    assign bus.ic_data_out = ic_data_q;
    assign bus.dc_rd_valid = dc_rd_valid_q;
    assign bus.dc_data_out = dc_data_q;

    // Burst tracking FSM. An accepted read opens a burst owned by its master
    // and loads beat_cnt with burst_len; each returning beat is registered
    // into the owner's data/valid outputs and counts down, and the beat seen
    // with beat_cnt at zero closes the burst. Beats arriving in IDLE belong
    // to nobody and are dropped. Writes never leave IDLE.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            last_grant    <= MASTER_IC;
            beat_cnt      <= '0;
            ic_rd_valid_q <= 1'b0;
            dc_rd_valid_q <= 1'b0;
            ic_data_q     <= '0;
            dc_data_q     <= '0;
        end else begin
            ic_rd_valid_q <= 1'b0;
            dc_rd_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept_ic) begin
                        last_grant <= MASTER_IC;
                        state      <= RD_IC;
                        beat_cnt   <= bus.ic_burst_len;
                    end else if (accept_dc) begin
                        last_grant <= MASTER_DC;
                        if (!bus.dc_wr) begin
                            state    <= RD_DC;
                            beat_cnt <= bus.dc_burst_len;
                        end
                    end
                end
                RD_IC: begin
                    if (bus.mem_rd_valid) begin
                        ic_data_q     <= bus.mem_data_out;
                        ic_rd_valid_q <= 1'b1;
                        if (beat_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - BURSTLEN_WIDTH'(1);
                        end
                    end
                end
                RD_DC: begin
                    if (bus.mem_rd_valid) begin
                        dc_data_q     <= bus.mem_data_out;
                        dc_rd_valid_q <= 1'b1;
                        if (beat_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - BURSTLEN_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Structural invariants of the merged port and the return path.
    a_strobe_onehot: assert property (@(posedge clock) disable iff (!reset_n)
        !(bus.mem_rd && bus.mem_wr));
    a_no_strobe_in_burst: assert property (@(posedge clock) disable iff (!reset_n)
        (state != IDLE) |-> !(bus.mem_rd || bus.mem_wr));
    a_valid_onehot: assert property (@(posedge clock) disable iff (!reset_n)
        !(ic_rd_valid_q && dc_rd_valid_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Stimulus pushes the expected memory
//   requests and read beats into queues; a monitor pops and compares them
//   whenever the arbiter presents an accepted memory request or a read beat.
//   A small word-addressed memory model answers accepted reads in wrap order
//   starting one cycle after acceptance and stores accepted writes.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 2;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] len;
        logic [DW-1:0] data;
    } req_t;

    logic clock;
    logic reset_n;
    logic stray;

    int check_count = 0;
    int error_count = 0;

    req_t          req_q[$];
    logic [DW-1:0] ic_q[$];
    logic [DW-1:0] dc_q[$];
    logic [DW-1:0] beat_q[$];
    logic [DW-1:0] mem_words [0:1023];

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so a stuck handshake can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [127:0] actual,
                                input logic [127:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic push_req(input logic wr, input logic [AW-1:0] addr,
                            input logic [BW-1:0] len, input logic [DW-1:0] data);
        req_t r;
        r.wr   = wr;
        r.addr = addr;
        r.len  = len;
        r.data = wr ? data : '0;
        req_q.push_back(r);
    endtask

    // Memory model: drives queued beats at the falling edge so the arbiter
    // samples them on the next rising edge, and commits accepted requests.
    initial begin
        for (int i = 0; i < 1024; i++) mem_words[i] = DW'(i);
        bus.mem_rd_valid = 1'b0;
        bus.mem_data_out = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                beat_q.delete();
                bus.mem_rd_valid = 1'b0;
                bus.mem_data_out = '0;
            end else begin
                if (stray) begin
                    bus.mem_rd_valid = 1'b1;
                    bus.mem_data_out = 32'hBAD0BAD0;
                end else if (beat_q.size() != 0) begin
                    bus.mem_rd_valid = 1'b1;
                    bus.mem_data_out = beat_q.pop_front();
                end else begin
                    bus.mem_rd_valid = 1'b0;
                    bus.mem_data_out = '0;
                end
                if (bus.mem_rd && !bus.mem_waitrequest) begin
                    logic [9:0] base;
                    logic [9:0] mask;
                    base = bus.mem_addr[11:2];
                    mask = 10'(bus.mem_burst_len);
                    for (int k = 0; k <= int'(bus.mem_burst_len); k++)
                        beat_q.push_back(mem_words[(base & ~mask) | ((base + 10'(k)) & mask)]);
                end
                if (bus.mem_wr && !bus.mem_waitrequest)
                    mem_words[bus.mem_addr[11:2]] = bus.mem_data_in;
            end
        end
    end

    // Monitor: compares every accepted memory request and every read beat
    // against the heads of the expectation queues.
    initial begin
        forever begin
            @(negedge clock);
            if ((bus.mem_rd || bus.mem_wr) && !bus.mem_waitrequest) begin
                check_output("mem_req_expected", 128'(req_q.size() != 0), 128'(1));
                if (req_q.size() != 0) begin
                    req_t e;
                    e = req_q.pop_front();
                    check_output("mem_req",
                        128'({bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_burst_len,
                              bus.mem_wr ? bus.mem_data_in : 32'h0}),
                        128'({e.wr, ~e.wr, e.addr, e.len, e.data}));
                end
            end
            if (bus.ic_rd_valid) begin
                check_output("ic_beat_expected", 128'(ic_q.size() != 0), 128'(1));
                if (ic_q.size() != 0) check_output("ic_beat_data", 128'(bus.ic_data_out), 128'(ic_q.pop_front()));
            end
            if (bus.dc_rd_valid) begin
                check_output("dc_beat_expected", 128'(dc_q.size() != 0), 128'(1));
                if (dc_q.size() != 0) check_output("dc_beat_data", 128'(bus.dc_data_out), 128'(dc_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_accept(input bit is_dc, input string name);
        bit accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clock);
            accepted = is_dc ? !bus.dc_waitrequest : !bus.ic_waitrequest;
        end
        check_output({name, "_accept"}, 128'(accepted), 128'(1));
        tick();
    endtask

    task automatic apply_ic_read(input logic [AW-1:0] addr, input logic [BW-1:0] len,
                                 input string name);
        bus.ic_rd        = 1'b1;
        bus.ic_addr      = addr;
        bus.ic_burst_len = len;
        wait_accept(1'b0, name);
        bus.ic_rd = 1'b0;
    endtask

    task automatic apply_dc(input logic wr, input logic rd, input logic [AW-1:0] addr,
                            input logic [BW-1:0] len, input logic [DW-1:0] data,
                            input string name);
        bus.dc_wr        = wr;
        bus.dc_rd        = rd;
        bus.dc_addr      = addr;
        bus.dc_burst_len = len;
        bus.dc_data_in   = data;
        wait_accept(1'b1, name);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && (req_q.size() + ic_q.size() + dc_q.size()) != 0; i++)
            @(negedge clock);
        check_output({name, "_drain"}, 128'(req_q.size() + ic_q.size() + dc_q.size()), 128'(0));
        tick();
    endtask

    task automatic apply_reset(input int cycles);
        reset_n = 1'b0;
        repeat (cycles) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        bit dc_done;
        bit ic_done;

        reset_n             = 1'b0;
        stray               = 1'b0;
        bus.mem_waitrequest = 1'b0;
        bus.ic_addr         = '0;
        bus.ic_burst_len    = '0;
        bus.ic_rd           = 1'b1;
        bus.dc_addr         = '0;
        bus.dc_burst_len    = '0;
        bus.dc_data_in      = '0;
        bus.dc_rd           = 1'b0;
        bus.dc_wr           = 1'b0;

        // Reset state, with an icache request already raised
        tick();
        tick();
        @(negedge clock);
        check_output("reset_strobes", 128'({bus.mem_rd, bus.mem_wr, bus.mem_addr}), 128'(0));
        check_output("reset_valids", 128'({bus.ic_rd_valid, bus.dc_rd_valid}), 128'(0));
        check_output("reset_data", 128'({bus.ic_data_out, bus.dc_data_out}), 128'(0));
        tick();
        bus.ic_rd = 1'b0;
        reset_n   = 1'b1;
        tick();

        // Lone icache burst of 4 beats
        push_req(1'b0, 32'h100, 2'd3, 32'h0);
        ic_q.push_back(32'h40); ic_q.push_back(32'h41);
        ic_q.push_back(32'h42); ic_q.push_back(32'h43);
        apply_ic_read(32'h100, 2'd3, "t1_ic");
        wait_drain("t1");
        @(negedge clock);
        check_output("idle_outputs",
            128'({bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.ic_waitrequest, bus.dc_waitrequest}),
            128'(0));
        tick();

        // Simultaneous requests after reset: dcache first, icache held off
        // until the cycle after the last dcache beat
        apply_reset(2);
        push_req(1'b0, 32'h300, 2'd3, 32'h0);
        push_req(1'b0, 32'h200, 2'd3, 32'h0);
        dc_q.push_back(32'hC0); dc_q.push_back(32'hC1);
        dc_q.push_back(32'hC2); dc_q.push_back(32'hC3);
        ic_q.push_back(32'h80); ic_q.push_back(32'h81);
        ic_q.push_back(32'h82); ic_q.push_back(32'h83);
        bus.ic_rd = 1'b1; bus.ic_addr = 32'h200; bus.ic_burst_len = 2'd3;
        bus.dc_rd = 1'b1; bus.dc_addr = 32'h300; bus.dc_burst_len = 2'd3;
        dc_done = 1'b0;
        ic_done = 1'b0;
        for (int c = 0; c < 40 && !ic_done; c++) begin
            @(negedge clock);
            if (!dc_done) begin
                check_output("conflict_dc_wins", 128'({bus.dc_waitrequest, bus.ic_waitrequest}), 128'(2'b01));
                dc_done = 1'b1;
            end else if (!bus.ic_waitrequest) begin
                ic_done = 1'b1;
                check_output("ic_after_dc_last", 128'({bus.dc_rd_valid, bus.dc_data_out}), 128'({1'b1, 32'hC3}));
            end else begin
                check_output("burst_blocks_mem_rd", 128'(bus.mem_rd), 128'(0));
            end
            tick();
            if (dc_done) bus.dc_rd = 1'b0;
            if (ic_done) bus.ic_rd = 1'b0;
        end
        check_output("ic_grant_in_time", 128'(ic_done), 128'(1));
        bus.ic_rd = 1'b0;
        wait_drain("t2");

        // Back-to-back writes (second with rd also high, write wins), then
        // read both words back
        push_req(1'b1, 32'h20, 2'd0, 32'hDEADBEEF);
        push_req(1'b1, 32'h24, 2'd0, 32'h12345678);
        push_req(1'b0, 32'h20, 2'd0, 32'h0);
        dc_q.push_back(32'hDEADBEEF);
        apply_dc(1'b1, 1'b0, 32'h20, 2'd0, 32'hDEADBEEF, "t3_wr0");
        apply_dc(1'b1, 1'b1, 32'h24, 2'd0, 32'h12345678, "t3_wr1");
        apply_dc(1'b0, 1'b1, 32'h20, 2'd0, 32'h0, "t3_rd0");
        bus.dc_rd = 1'b0;
        wait_drain("t3a");
        push_req(1'b0, 32'h24, 2'd0, 32'h0);
        dc_q.push_back(32'h12345678);
        apply_dc(1'b0, 1'b1, 32'h24, 2'd0, 32'h0, "t3_rd1");
        bus.dc_rd = 1'b0;
        wait_drain("t3b");

        // Make icache the last grant, then stall a dcache write while the
        // icache also requests: the write keeps the grant through the stall
        push_req(1'b0, 32'h100, 2'd0, 32'h0);
        ic_q.push_back(32'h40);
        apply_ic_read(32'h100, 2'd0, "t5_pre");
        wait_drain("t5_pre");
        push_req(1'b1, 32'h40, 2'd0, 32'hCAFEF00D);
        push_req(1'b0, 32'h404, 2'd1, 32'h0);
        ic_q.push_back(32'h101); ic_q.push_back(32'h100);
        bus.mem_waitrequest = 1'b1;
        bus.dc_wr = 1'b1; bus.dc_addr = 32'h40; bus.dc_burst_len = 2'd0; bus.dc_data_in = 32'hCAFEF00D;
        bus.ic_rd = 1'b1; bus.ic_addr = 32'h404; bus.ic_burst_len = 2'd1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            check_output("stall_held", 128'({bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_data_in}),
                         128'({1'b1, 1'b0, 32'h40, 32'hCAFEF00D}));
            check_output("stall_wait", 128'({bus.dc_waitrequest, bus.ic_waitrequest}), 128'(2'b11));
            tick();
        end
        bus.mem_waitrequest = 1'b0;
        @(negedge clock);
        check_output("stall_accept_4th", 128'({bus.dc_waitrequest, bus.ic_waitrequest}), 128'(2'b01));
        tick();
        bus.dc_wr = 1'b0;
        wait_accept(1'b0, "t5_ic");
        bus.ic_rd = 1'b0;
        wait_drain("t5");

        // Reset after 2 of 4 beats, stray beats while idle, then a clean burst
        push_req(1'b0, 32'h100, 2'd3, 32'h0);
        ic_q.push_back(32'h40); ic_q.push_back(32'h41);
        apply_ic_read(32'h100, 2'd3, "t6_ic");
        ic_done = 1'b0;
        for (int c = 0; c < 20 && !ic_done; c++) begin
            @(negedge clock);
            ic_done = bus.ic_rd_valid && (bus.ic_data_out == 32'h41);
        end
        check_output("t6_second_beat", 128'(ic_done), 128'(1));
        reset_n = 1'b0;
        tick();
        tick();
        @(negedge clock);
        check_output("t6_reset_drops", 128'({bus.ic_rd_valid, bus.dc_rd_valid}), 128'(0));
        tick();
        reset_n = 1'b1;
        tick();
        stray = 1'b1;
        tick();
        tick();
        stray = 1'b0;
        @(negedge clock);
        check_output("stray_ignored", 128'({bus.ic_rd_valid, bus.dc_rd_valid}), 128'(0));
        tick();
        tick();
        push_req(1'b0, 32'h100, 2'd3, 32'h0);
        ic_q.push_back(32'h40); ic_q.push_back(32'h41);
        ic_q.push_back(32'h42); ic_q.push_back(32'h43);
        apply_ic_read(32'h100, 2'd3, "t6_after");
        wait_drain("t6");

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
